// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor on the free-running refclk: sequences pll_rst and
// releases sys_rst_n only after lock has been continuously present for STABLE_CYCLES.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 40000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 16,
    parameter int RETRY_W        = 4
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    input  logic               soft_rst,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               lock_lost,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_count,
    output logic [RETRY_W-1:0] lost_count,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'b00,
        WAIT_LOCK = 2'b01,
        STABILIZE = 2'b10,
        RUN       = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = {RETRY_W{1'b1}};
    localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(2**RETRY_W - 2);

    state_t           state_q;
    logic [CNT_W-1:0] cnt;
    logic             lk_meta;
    logic             lk_s;

    assign state = state_q;

    // locked comes straight from the PLL and is asynchronous to refclk.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= locked;
            lk_s    <= lk_meta;
        end
    end

    // Outputs are updated on the same edge as the state they belong to, so
    // pll_rst/sys_rst_n always agree with state as seen from outside.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q     <= RESET_PLL;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_rst_n   <= 1'b0;
            lock_lost   <= 1'b0;
            fail        <= 1'b0;
            retry_count <= '0;
            lost_count  <= '0;
        end else begin
            lock_lost <= 1'b0;
            if (soft_rst) begin
                state_q   <= RESET_PLL;
                cnt       <= '0;
                pll_rst   <= 1'b1;
                sys_rst_n <= 1'b0;
            end else begin
                case (state_q)
                    RESET_PLL: begin
                        if (cnt == RST_LAST) begin
                            state_q <= WAIT_LOCK;
                            cnt     <= '0;
                            pll_rst <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        // Lock is checked first so it beats a timeout on the same cycle.
                        if (lk_s) begin
                            state_q <= STABILIZE;
                            cnt     <= '0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            state_q <= RESET_PLL;
                            cnt     <= '0;
                            pll_rst <= 1'b1;
                            if (retry_count != RETRY_MAX) begin
                                retry_count <= retry_count + 1'b1;
                                if (retry_count == RETRY_LAST) begin
                                    fail <= 1'b1;
                                end
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STABILIZE: begin
                        if (!lk_s) begin
                            state_q <= WAIT_LOCK;
                            cnt     <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            state_q   <= RUN;
                            cnt       <= '0;
                            sys_rst_n <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (!lk_s) begin
                            state_q   <= RESET_PLL;
                            cnt       <= '0;
                            pll_rst   <= 1'b1;
                            sys_rst_n <= 1'b0;
                            lock_lost <= 1'b1;
                            if (lost_count != RETRY_MAX) begin
                                lost_count <= lost_count + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q   <= RESET_PLL;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        sys_rst_n <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scenario bench for pll_lock_supervisor with short sim parameters
// (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, RETRY_W=2).
module tb_pll_lock_supervisor;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       soft_rst;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       lock_lost;
    logic       fail;
    logic [1:0] retry_count;
    logic [1:0] lost_count;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int ll_seen;
    logic [15:0] exp_q[$];
    logic [15:0] exp;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .CNT_W         (16),
        .RETRY_W       (2)
    ) dut (
        .refclk     (clk),
        .rst        (rst),
        .locked     (locked),
        .soft_rst   (soft_rst),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .lock_lost  (lock_lost),
        .fail       (fail),
        .retry_count(retry_count),
        .lost_count (lost_count),
        .state      (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] pack(input logic pr, input logic sr, input logic ll,
                                         input logic f, input logic [1:0] rc,
                                         input logic [1:0] lc, input logic [1:0] st);
        return {6'b0, pr, sr, ll, f, rc, lc, st};
    endfunction

    function automatic logic [15:0] obs_now();
        return {6'b0, pll_rst, sys_rst_n, lock_lost, fail, retry_count, lost_count, state};
    endfunction

    // driver tasks; outputs are sampled and inputs driven on the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        locked = 1'b0;
        soft_rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Counts samples with pll_rst high, including the current one.
    task automatic count_high(output int n);
        n = 0;
        ll_seen = 0;
        while (pll_rst === 1'b1 && n < 200) begin
            if (lock_lost === 1'b1) ll_seen++;
            n++;
            step();
        end
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (pll_rst === 1'b0 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic wait_sys(output int n, output int viol);
        n = 0;
        viol = 0;
        do begin
            step();
            n++;
            if (sys_rst_n === 1'b1 && state !== 2'b11) viol++;
        end while (sys_rst_n !== 1'b1 && n < 200);
    endtask

    task automatic bring_up();
        int n, v;
        do_reset();
        count_high(n);
        locked = 1'b1;
        wait_sys(n, v);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        locked = 1'b0;
        soft_rst = 1'b0;
        step();
        step();
        exp_q.push_back(pack(1, 0, 0, 0, 2'd0, 2'd0, 2'b00));
        exp = exp_q.pop_front(); checks++;
        if (obs_now() !== exp) begin
            errors++; $display("FAIL reset_outputs actual=%h required=%h", obs_now(), exp);
        end
    endtask

    task automatic test_bringup();
        int n, v;
        do_reset();
        exp_q.push_back(16'd4);
        count_high(n);
        exp = exp_q.pop_front(); checks++;
        if (16'(n) !== exp) begin
            errors++; $display("FAIL bringup_pll_rst_width actual=%0d required=%0d", n, exp);
        end
        step();
        step();
        locked = 1'b1;
        exp_q.push_back(16'd11);
        wait_sys(n, v);
        exp = exp_q.pop_front(); checks++;
        if (16'(n) !== exp) begin
            errors++; $display("FAIL bringup_sys_latency actual=%0d required=%0d", n, exp);
        end
        checks++;
        if (v !== 0) begin
            errors++; $display("FAIL bringup_sys_outside_run actual=%0d required=0", v);
        end
        exp_q.push_back(pack(0, 1, 0, 0, 2'd0, 2'd0, 2'b11));
        exp = exp_q.pop_front(); checks++;
        if (obs_now() !== exp) begin
            errors++; $display("FAIL bringup_run_outputs actual=%h required=%h", obs_now(), exp);
        end
    endtask

    task automatic test_timeout();
        int h, l;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(16'd4);
            exp_q.push_back(16'd20);
            exp_q.push_back(pack(1, 0, 0, k >= 3, (k >= 3) ? 2'd3 : 2'(k), 2'd0, 2'b00));
            count_high(h);
            count_low(l);
            exp = exp_q.pop_front(); checks++;
            if (16'(h) !== exp) begin
                errors++; $display("FAIL timeout_high_%0d actual=%0d required=%0d", k, h, exp);
            end
            exp = exp_q.pop_front(); checks++;
            if (16'(l) !== exp) begin
                errors++; $display("FAIL timeout_low_%0d actual=%0d required=%0d", k, l, exp);
            end
            exp = exp_q.pop_front(); checks++;
            if (obs_now() !== exp) begin
                errors++; $display("FAIL timeout_outputs_%0d actual=%h required=%h", k, obs_now(), exp);
            end
        end
    endtask

    task automatic test_lock_loss();
        int n, h, v;
        bring_up();
        locked = 1'b0;
        step();
        locked = 1'b1;
        exp_q.push_back(16'd2);
        n = 0;
        while (lock_lost !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        exp = exp_q.pop_front(); checks++;
        if (16'(n) !== exp) begin
            errors++; $display("FAIL loss_detect_latency actual=%0d required=%0d", n, exp);
        end
        exp_q.push_back(pack(1, 0, 1, 0, 2'd0, 2'd1, 2'b00));
        exp = exp_q.pop_front(); checks++;
        if (obs_now() !== exp) begin
            errors++; $display("FAIL loss_outputs actual=%h required=%h", obs_now(), exp);
        end
        exp_q.push_back(16'd4);
        exp_q.push_back(16'd1);
        count_high(h);
        exp = exp_q.pop_front(); checks++;
        if (16'(h) !== exp) begin
            errors++; $display("FAIL loss_pll_rst_width actual=%0d required=%0d", h, exp);
        end
        exp = exp_q.pop_front(); checks++;
        if (16'(ll_seen) !== exp) begin
            errors++; $display("FAIL loss_pulse_cycles actual=%0d required=%0d", ll_seen, exp);
        end
        exp_q.push_back(16'd9);
        wait_sys(n, v);
        exp = exp_q.pop_front(); checks++;
        if (16'(n) !== exp) begin
            errors++; $display("FAIL loss_relock_latency actual=%0d required=%0d", n, exp);
        end
        exp_q.push_back(pack(0, 1, 0, 0, 2'd0, 2'd1, 2'b11));
        exp = exp_q.pop_front(); checks++;
        if (obs_now() !== exp) begin
            errors++; $display("FAIL loss_rerun_outputs actual=%h required=%h", obs_now(), exp);
        end
    endtask

    task automatic test_stabilize_drop();
        int n, h, v;
        do_reset();
        count_high(h);
        locked = 1'b1;
        n = 0;
        while (state !== 2'b10 && n < 50) begin
            step();
            n++;
        end
        // Drop timed so the synchronized low arrives while the stability count is 5.
        step();
        step();
        step();
        locked = 1'b0;
        step();
        locked = 1'b1;
        step();
        exp_q.push_back(16'(2'b10));
        exp = exp_q.pop_front(); checks++;
        if (16'(state) !== exp) begin
            errors++; $display("FAIL stab_before_drop actual=%0d required=%0d", state, exp);
        end
        step();
        exp_q.push_back(pack(0, 0, 0, 0, 2'd0, 2'd0, 2'b01));
        exp = exp_q.pop_front(); checks++;
        if (obs_now() !== exp) begin
            errors++; $display("FAIL stab_drop_outputs actual=%h required=%h", obs_now(), exp);
        end
        exp_q.push_back(16'd9);
        wait_sys(n, v);
        exp = exp_q.pop_front(); checks++;
        if (16'(n) !== exp) begin
            errors++; $display("FAIL stab_full_restart actual=%0d required=%0d", n, exp);
        end
    endtask

    task automatic test_soft_priority();
        int h, v;
        bring_up();
        locked = 1'b0;
        step();
        step();
        soft_rst = 1'b1;
        step();
        exp_q.push_back(pack(1, 0, 0, 0, 2'd0, 2'd0, 2'b00));
        exp = exp_q.pop_front(); checks++;
        if (obs_now() !== exp) begin
            errors++; $display("FAIL soft_vs_loss_outputs actual=%h required=%h", obs_now(), exp);
        end
        v = 0;
        for (int i = 2; i <= 10; i++) begin
            step();
            if (pll_rst !== 1'b1 || lock_lost !== 1'b0 || state !== 2'b00) v++;
        end
        checks++;
        if (v !== 0) begin
            errors++; $display("FAIL soft_hold_pll_rst actual=%0d required=0", v);
        end
        soft_rst = 1'b0;
        locked = 1'b1;
        exp_q.push_back(16'd4);
        count_high(h);
        exp = exp_q.pop_front(); checks++;
        if (16'(h) !== exp) begin
            errors++; $display("FAIL soft_release_width actual=%0d required=%0d", h, exp);
        end
        exp_q.push_back(pack(0, 0, 0, 0, 2'd0, 2'd0, 2'b01));
        exp = exp_q.pop_front(); checks++;
        if (obs_now() !== exp) begin
            errors++; $display("FAIL soft_after_outputs actual=%h required=%h", obs_now(), exp);
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        n = 0;
        while (fail !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        exp_q.push_back(pack(1, 0, 0, 1, 2'd3, 2'd0, 2'b00));
        exp = exp_q.pop_front(); checks++;
        if (obs_now() !== exp) begin
            errors++; $display("FAIL async_pre_fail actual=%h required=%h", obs_now(), exp);
        end
        locked = 1'b1;
        n = 0;
        while (state !== 2'b10 && n < 50) begin
            step();
            n++;
        end
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        exp_q.push_back(pack(1, 0, 0, 0, 2'd0, 2'd0, 2'b00));
        exp = exp_q.pop_front(); checks++;
        if (obs_now() !== exp) begin
            errors++; $display("FAIL async_abort_outputs actual=%h required=%h", obs_now(), exp);
        end
        step();
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_timeout();
        test_lock_loss();
        test_stabilize_drop();
        test_soft_priority();
        test_async_reset();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
